vga_fb_axi_rd_slave: RTL and testbench

//  AXI4 read responder that serves the VGA line-fetch bursts from an on-chip frame buffer SRAM.

---
 rtl/vga_fb_axi_rd_slave.sv | 160 ++++++++++++++++
 tb/tb_vga_fb_axi_rd_slave.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_axi_rd_slave.sv
// AXI4 read responder serving VGA line-fetch bursts from an on-chip frame buffer SRAM.
// One burst outstanding; a 2-entry output FIFO behind the SRAM gives full R-channel backpressure.
module vga_fb_axi_rd_slave #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     arvalid_i,
    output logic                     arready_o,
    input  logic [ADDR_WIDTH-1:0]    araddr_i,
    input  logic [1:0]               arburst_i,
    input  logic [7:0]               arlen_i,
    input  logic [2:0]               arsize_i,
    output logic                     rvalid_o,
    input  logic                     rready_i,
    output logic [DATA_WIDTH-1:0]    rdata_o,
    output logic [1:0]               rresp_o,
    output logic                     rlast_o,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0]    wdata_i
);

    localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W      = $clog2(DEPTH);
    localparam int WORD_W     = ADDR_WIDTH - BYTE_SHIFT;

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] ram_q;

    logic [WORD_W-1:0] cur_word;
    logic [1:0]        burst_q;
    logic [7:0]        len_q;
    logic [7:0]        beat_cnt;
    logic              slverr_q;

    logic       inf_valid;
    logic       inf_ok;
    logic [1:0] inf_resp;
    logic       inf_last;

    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic [1:0]            fifo_resp [2];
    logic                  fifo_last [2];
    logic                  wr_ptr, rd_ptr;
    logic [1:0]            count;

    logic       ar_fire, r_fire, issue, issue_last, push, pop;
    logic [1:0] beat_resp;

    assign ar_fire    = arvalid_i && arready_o;
    assign r_fire     = rvalid_o && rready_i;
    assign issue_last = (beat_cnt == len_q);
    // The word index is kept narrower than the address so an address below BASE_ADDR
    // lands far above DEPTH and reports DECERR without a separate flag.
    assign beat_resp  = slverr_q ? 2'b10 :
                        (cur_word < WORD_W'(DEPTH)) ? 2'b00 : 2'b11;
    assign push       = inf_valid && !((count == 2'd0) && r_fire);
    assign pop        = (count != 2'd0) && r_fire;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ar_fire) state_nxt = BURST;
            BURST:   if (issue && issue_last) state_nxt = DRAIN;
            DRAIN:   if (r_fire && rlast_o) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        arready_o = (state == IDLE) && !reset;
        issue     = (state == BURST) && (({1'b0, count} + {2'b0, inf_valid}) < 3'd2);
    end

    // Preload port and the one-cycle registered SRAM read; a same-cycle write returns old data.
    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
        if (issue) ram_q <= mem[cur_word[IDX_W-1:0]];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_word  <= '0;
            burst_q   <= 2'b00;
            len_q     <= 8'd0;
            beat_cnt  <= 8'd0;
            slverr_q  <= 1'b0;
            inf_valid <= 1'b0;
            inf_ok    <= 1'b0;
            inf_resp  <= 2'b00;
            inf_last  <= 1'b0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
        end else begin
            if (ar_fire) begin
                cur_word <= WORD_W'((araddr_i - BASE_ADDR) >> BYTE_SHIFT);
                burst_q  <= arburst_i;
                len_q    <= arlen_i;
                beat_cnt <= 8'd0;
                slverr_q <= arburst_i[1] || (arsize_i != 3'(BYTE_SHIFT));
            end else if (issue) begin
                if (!issue_last) beat_cnt <= beat_cnt + 8'd1;
                if (burst_q == 2'b01) cur_word <= cur_word + WORD_W'(1);
            end
            inf_valid <= issue;
            if (issue) begin
                inf_ok   <= (beat_resp == 2'b00);
                inf_resp <= beat_resp;
                inf_last <= issue_last;
            end
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= inf_ok ? ram_q : '0;
            fifo_resp[wr_ptr] <= inf_resp;
            fifo_last[wr_ptr] <= inf_last;
        end
    end

    // An empty FIFO lets the SRAM output go straight to R, which gives the two-cycle AR-to-R latency.
    always_comb begin
        rvalid_o = 1'b0;
        rdata_o  = '0;
        rresp_o  = 2'b00;
        rlast_o  = 1'b0;
        if (!reset) begin
            if (count != 2'd0) begin
                rvalid_o = 1'b1;
                rdata_o  = fifo_data[rd_ptr];
                rresp_o  = fifo_resp[rd_ptr];
                rlast_o  = fifo_last[rd_ptr];
            end else if (inf_valid) begin
                rvalid_o = 1'b1;
                rdata_o  = inf_ok ? ram_q : '0;
                rresp_o  = inf_resp;
                rlast_o  = inf_last;
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_axi_rd_slave.sv
// Scoreboard bench for vga_fb_axi_rd_slave: directed bursts push expected beats,
// a negedge monitor pops and compares every accepted R beat and checks stall stability.
module tb_vga_fb_axi_rd_slave;

    localparam int AW    = 64;
    localparam int DW    = 64;
    localparam int DEPTH = 4096;

    logic          clk = 1'b0;
    logic          reset;
    logic          arvalid_i;
    logic          arready_o;
    logic [AW-1:0] araddr_i;
    logic [1:0]    arburst_i;
    logic [7:0]    arlen_i;
    logic [2:0]    arsize_i;
    logic          rvalid_o;
    logic          rready_i;
    logic [DW-1:0] rdata_o;
    logic [1:0]    rresp_o;
    logic          rlast_o;
    logic          we_i;
    logic [11:0]   waddr_i;
    logic [DW-1:0] wdata_i;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    beat_t sb_q[$];
    int    checks     = 0;
    int    passes     = 0;
    int    beats_seen = 0;
    bit    toggle_mode = 1'b0;
    bit    stalled    = 1'b0;
    beat_t held;
    beat_t exp_beat;

    vga_fb_axi_rd_slave #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DEPTH(DEPTH),
        .BASE_ADDR(64'd0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .arvalid_i(arvalid_i),
        .arready_o(arready_o),
        .araddr_i(araddr_i),
        .arburst_i(arburst_i),
        .arlen_i(arlen_i),
        .arsize_i(arsize_i),
        .rvalid_o(rvalid_o),
        .rready_i(rready_i),
        .rdata_o(rdata_o),
        .rresp_o(rresp_o),
        .rlast_o(rlast_o),
        .we_i(we_i),
        .waddr_i(waddr_i),
        .wdata_i(wdata_i)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    endtask

    task automatic pushBeat(input logic [63:0] data, input logic [1:0] resp, input logic last);
        beat_t b;
        b.data = data;
        b.resp = resp;
        b.last = last;
        sb_q.push_back(b);
    endtask

    // Called #1 after a posedge; returns #1 after the edge on which AR handshakes.
    task automatic applyStimulus(input logic [63:0] addr, input logic [1:0] burst,
                                 input logic [7:0] len, input logic [2:0] size, input bit push_model);
        logic [63:0] w;
        int n;
        if (push_model) begin
            for (int i = 0; i <= int'(len); i++) begin
                w = (burst == 2'b01) ? (addr >> 3) + 64'(i) : (addr >> 3);
                if (burst[1] || size != 3'd3) pushBeat(64'd0, 2'b10, i == int'(len));
                else if (w >= 64'(DEPTH))     pushBeat(64'd0, 2'b11, i == int'(len));
                else                          pushBeat(w * 3, 2'b00, i == int'(len));
            end
        end
        arvalid_i = 1'b1;
        araddr_i  = addr;
        arburst_i = burst;
        arlen_i   = len;
        arsize_i  = size;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!arready_o && n < 200);
        if (!arready_o) checkOutput("ar_handshake_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        arvalid_i = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            checkOutput("drain_timeout_remaining", 64'(sb_q.size()), 64'd0);
            sb_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic writeWord(input logic [11:0] addr, input logic [63:0] data);
        we_i    = 1'b1;
        waddr_i = addr;
        wdata_i = data;
        @(posedge clk);
        #1;
        we_i = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rready_i = toggle_mode ? ~rready_i : 1'b1;
        end
    end

    // Monitor: a beat is accepted on the posedge following a negedge where rvalid&rready.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    if (!rvalid_o) begin
                        checkOutput("rvalid_held_while_stalled", 64'(rvalid_o), 64'd1);
                    end else begin
                        checkOutput("stall_rdata_stable", rdata_o, held.data);
                        checkOutput("stall_rresp_stable", 64'(rresp_o), 64'(held.resp));
                        checkOutput("stall_rlast_stable", 64'(rlast_o), 64'(held.last));
                    end
                end
                stalled = 1'b0;
                if (rvalid_o) begin
                    if (rready_i) begin
                        if (sb_q.size() == 0) begin
                            checkOutput("unexpected_beat", 64'd1, 64'd0);
                        end else begin
                            exp_beat = sb_q.pop_front();
                            checkOutput("rdata", rdata_o, exp_beat.data);
                            checkOutput("rresp", 64'(rresp_o), 64'(exp_beat.resp));
                            checkOutput("rlast", 64'(rlast_o), 64'(exp_beat.last));
                            beats_seen++;
                        end
                    end else begin
                        held.data = rdata_o;
                        held.resp = rresp_o;
                        held.last = rlast_o;
                        stalled   = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", passes, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int start;
        int n;
        reset     = 1'b1;
        arvalid_i = 1'b0;
        araddr_i  = '0;
        arburst_i = 2'b01;
        arlen_i   = 8'd0;
        arsize_i  = 3'd3;
        rready_i  = 1'b1;
        we_i      = 1'b0;
        waddr_i   = '0;
        wdata_i   = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_arready", 64'(arready_o), 64'd0);
        checkOutput("reset_rvalid", 64'(rvalid_o), 64'd0);
        checkOutput("reset_rlast", 64'(rlast_o), 64'd0);
        checkOutput("reset_rresp", 64'(rresp_o), 64'd0);
        checkOutput("reset_rdata", rdata_o, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("arready_after_reset", 64'(arready_o), 64'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < DEPTH; i++) writeWord(12'(i), 64'(i * 3));

        $display("[TB] INCR len=7 from base, rready held high");
        applyStimulus(64'd0, 2'b01, 8'd7, 3'd3, 1'b1);
        @(negedge clk);
        checkOutput("latency_T+1_rvalid", 64'(rvalid_o), 64'd0);
        @(negedge clk);
        checkOutput("latency_T+2_rvalid", 64'(rvalid_o), 64'd1);
        waitDrain();

        $display("[TB] INCR len=7 with rready toggling");
        toggle_mode = 1'b1;
        applyStimulus(64'd0, 2'b01, 8'd7, 3'd3, 1'b1);
        waitDrain();
        toggle_mode = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] FIXED word 5 len=3");
        applyStimulus(64'd40, 2'b00, 8'd3, 3'd3, 1'b1);
        waitDrain();

        $display("[TB] INCR crossing the top of the buffer");
        applyStimulus(64'((DEPTH - 2) * 8), 2'b01, 8'd3, 3'd3, 1'b1);
        waitDrain();

        $display("[TB] WRAP and narrow size bursts, then a legal burst");
        applyStimulus(64'd0, 2'b10, 8'd3, 3'd3, 1'b1);
        waitDrain();
        applyStimulus(64'd0, 2'b01, 8'd3, 3'd2, 1'b1);
        waitDrain();
        applyStimulus(64'd80, 2'b01, 8'd1, 3'd3, 1'b1);
        waitDrain();

        $display("[TB] single-beat burst");
        applyStimulus(64'd24, 2'b01, 8'd0, 3'd3, 1'b1);
        waitDrain();

        $display("[TB] preload collision on word 7");
        pushBeat(64'd21, 2'b00, 1'b0);
        pushBeat(64'd999, 2'b00, 1'b1);
        applyStimulus(64'd56, 2'b00, 8'd1, 3'd3, 1'b0);
        writeWord(12'd7, 64'd999);
        waitDrain();
        writeWord(12'd7, 64'd21);

        $display("[TB] reset in the middle of a len=15 burst");
        start = beats_seen;
        applyStimulus(64'd0, 2'b01, 8'd15, 3'd3, 1'b1);
        n = 0;
        while (beats_seen < start + 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("beats_before_reset", 64'(beats_seen - start), 64'd2);
        @(posedge clk);
        #1;
        reset = 1'b1;
        sb_q.delete();
        @(negedge clk);
        checkOutput("rvalid_during_reset", 64'(rvalid_o), 64'd0);
        checkOutput("arready_during_reset", 64'(arready_o), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("arready_after_midburst_reset", 64'(arready_o), 64'd1);
        checkOutput("rvalid_after_midburst_reset", 64'(rvalid_o), 64'd0);
        @(posedge clk);
        #1;
        applyStimulus(64'd16, 2'b01, 8'd2, 3'd3, 1'b1);
        waitDrain();

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
